// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scan driver with PWM
// brightness, per-digit enable, decimal points and frame-synchronous blink.
// One digit slot lasts 16*DWELL_MUL clocks; every slot is always visited,
// so a frame is exactly NDIGITS slots long.
module seg_scan_driver #(
  parameter int NDIGITS      = 8,
  parameter int DWELL_MUL    = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   digit_val,
  input  logic [NDIGITS-1:0]     dot,
  input  logic [NDIGITS-1:0]     en,
  input  logic [NDIGITS-1:0]     blink,
  input  logic [3:0]             brightness,
  output logic [NDIGITS-1:0]     AN,
  output logic [7:0]             HEX,
  output logic                   frame_start
);

  localparam int DWELL = 16 * DWELL_MUL;
  localparam int CW    = $clog2(DWELL);
  localparam int SW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
  localparam logic [SW-1:0] SEL_LAST  = SW'(NDIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] MUL_CW    = CW'(DWELL_MUL);

  logic [SW-1:0]      sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic               blink_off_q, blink_off_d;
  logic [NDIGITS-1:0] an_q, an_d;
  logic [7:0]         hex_q, hex_d;
  logic               frame_start_q, frame_start_d;

  logic               slotEnd;
  logic               frameEnd;
  logic [CW-1:0]      phase;
  logic [3:0]         nibble;
  logic               lit;

  // Active-low segment patterns, bit order g..a.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Scan position: clock within slot, digit within frame, frame within blink half-period.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    sel_d       = sel_q;
    fcnt_d      = fcnt_q;
    blink_off_d = blink_off_q;
    slotEnd     = (cnt_q == CNT_LAST);
    frameEnd    = slotEnd && (sel_q == SEL_LAST);
    if (slotEnd) begin
      cnt_d = '0;
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
    end
    if (frameEnd) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d      = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Output decision from the pre-edge scan state; the first clock of each slot stays dark to avoid ghosting.
  always_comb begin
    an_d          = '1;
    hex_d         = 8'hFF;
    phase         = cnt_q / MUL_CW;
    nibble        = digit_val[4*sel_q +: 4];
    lit           = (cnt_q != '0) && (phase <= CW'(brightness)) && en[sel_q] &&
                    !(blink[sel_q] && blink_off_q);
    frame_start_d = (sel_q == '0) && (cnt_q == '0);
    if (lit) begin
      an_d[sel_q] = 1'b0;
      hex_d       = {~dot[sel_q], decode(nibble)};
    end
  end

  // State and registered outputs; reset may land at any point in a slot.
  always_ff @(posedge clock) begin
    if (!rst) begin
      sel_q         <= '0;
      cnt_q         <= '0;
      fcnt_q        <= '0;
      blink_off_q   <= 1'b0;
      an_q          <= '1;
      hex_q         <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      fcnt_q        <= fcnt_d;
      blink_off_q   <= blink_off_d;
      an_q          <= an_d;
      hex_q         <= hex_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign AN          = an_q;
  assign HEX         = hex_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver: an 8-digit instance with
// a 2-frame blink half-period and a 6-digit instance for non-power-of-2 wrap.
module tb_seg_scan_driver;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] digitVal;
  logic [7:0]  dot, en, blink;
  logic [3:0]  brightness;
  logic [7:0]  AN;
  logic [7:0]  HEX;
  logic        frame_start;

  logic        rst6;
  logic [23:0] digitVal6;
  logic [5:0]  dot6, en6, blink6;
  logic [3:0]  brightness6;
  logic [5:0]  AN6;
  logic [7:0]  HEX6;
  logic        frameStart6;

  int checks   = 0;
  int failures = 0;
  int edgeNum  = 0;
  int lastFs   = 0;
  int fsPeriod = 0;
  int an5Low   = 0;

  logic [7:0] hexLetters [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  seg_scan_driver #(.NDIGITS(8), .DWELL_MUL(1), .BLINK_FRAMES(2)) u8 (
    .clock(clock), .rst(rst), .digit_val(digitVal), .dot(dot), .en(en),
    .blink(blink), .brightness(brightness), .AN(AN), .HEX(HEX),
    .frame_start(frame_start)
  );

  seg_scan_driver #(.NDIGITS(6), .DWELL_MUL(1), .BLINK_FRAMES(2)) u6 (
    .clock(clock), .rst(rst6), .digit_val(digitVal6), .dot(dot6), .en(en6),
    .blink(blink6), .brightness(brightness6), .AN(AN6), .HEX(HEX6),
    .frame_start(frameStart6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] dv, input logic [7:0] d,
                               input logic [7:0] e, input logic [7:0] b,
                               input logic [3:0] br);
    digitVal   = dv;
    dot        = d;
    en         = e;
    blink      = b;
    brightness = br;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edgeNum++;
    if (AN[5] === 1'b0) an5Low++;
    if (frame_start === 1'b1) begin
      if (lastFs != 0) fsPeriod = edgeNum - lastFs;
      lastFs = edgeNum;
    end
  endtask

  task automatic runTo(input int n);
    while (edgeNum < n) tick();
  endtask

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [5:0] an6Exp;
    int s;

    rst  = 1'b0;
    rst6 = 1'b0;
    applyStimulus(32'hDEADBEEF, 8'hA5, 8'hFF, 8'h3C, 4'hF);
    digitVal6   = 24'hFEDCBA;
    dot6        = 6'h00;
    en6         = 6'h3F;
    blink6      = 6'h00;
    brightness6 = 4'hF;

    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("reset_hold", {AN, HEX, 7'd0, frame_start}, {8'hFF, 8'hFF, 8'h00});
    end

    applyStimulus(32'h76543210, 8'h00, 8'hFF, 8'h00, 4'hF);
    rst     = 1'b1;
    edgeNum = 0;
    lastFs  = 0;

    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("first_edge_an", AN, 8'hFF);
        checkOutput("first_edge_fs", frame_start, 1'b1);
      end else if (k <= 16) begin
        checkOutput("digit0_lit", {AN, HEX}, {8'hFE, 8'hC0});
      end else if (k == 17) begin
        checkOutput("digit1_ghost_blank", AN, 8'hFF);
      end else begin
        checkOutput("digit1_lit", {AN, HEX}, {8'hFD, 8'hF9});
      end
    end

    runTo(128);
    checkOutput("digit7_last_clock", {AN, HEX}, {8'h7F, 8'hF8});
    tick();
    checkOutput("frame1_fs", frame_start, 1'b1);
    checkOutput("frame_period_a", fsPeriod, 128);

    applyStimulus(32'h76543210, 8'h01, 8'hFF, 8'h00, 4'h3);
    for (int k = 130; k <= 144; k++) begin
      tick();
      if (k <= 132) checkOutput("pwm3_on_dot", {AN, HEX}, {8'hFE, 8'h40});
      else          checkOutput("pwm3_off", {AN, HEX}, {8'hFF, 8'hFF});
    end

    applyStimulus(32'h76543210, 8'h00, 8'hDF, 8'h04, 4'hF);
    an5Low = 0;
    runTo(170);
    checkOutput("blink_digit2_frame1_lit", {AN, HEX}, {8'hFB, 8'hA4});
    runTo(213);
    checkOutput("digit5_disabled", {AN, HEX}, {8'hFF, 8'hFF});
    runTo(256);
    checkOutput("fs_low_before_frame2", frame_start, 1'b0);
    tick();
    checkOutput("frame2_fs", frame_start, 1'b1);
    checkOutput("frame_period_b", fsPeriod, 128);
    runTo(296);
    checkOutput("blink_digit2_frame2_off", {AN, HEX}, {8'hFF, 8'hFF});
    runTo(314);
    checkOutput("digit3_frame2_unblinked", {AN, HEX}, {8'hF7, 8'hB0});
    runTo(424);
    checkOutput("blink_digit2_frame3_off", {AN, HEX}, {8'hFF, 8'hFF});
    runTo(552);
    checkOutput("blink_digit2_frame4_lit", {AN, HEX}, {8'hFB, 8'hA4});
    checkOutput("an5_never_low", an5Low, 0);

    runTo(697);
    checkOutput("pre_reset_digit3", {AN, HEX}, {8'hF7, 8'hB0});
    rst = 1'b0;
    tick();
    checkOutput("mid_slot_reset", {AN, HEX, 7'd0, frame_start}, {8'hFF, 8'hFF, 8'h00});
    rst     = 1'b1;
    edgeNum = 0;
    lastFs  = 0;
    tick();
    checkOutput("restart_fs", {AN, 7'd0, frame_start}, {8'hFF, 8'h01});
    tick();
    checkOutput("restart_digit0", {AN, HEX}, {8'hFE, 8'hC0});
    runTo(17);
    checkOutput("restart_digit1_blank", AN, 8'hFF);
    runTo(18);
    checkOutput("restart_digit1_lit", {AN, HEX}, {8'hFD, 8'hF9});
    runTo(129);
    checkOutput("restart_frame1_fs", frame_start, 1'b1);
    checkOutput("restart_period", fsPeriod, 128);

    rst6 = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("n6_first_fs", frameStart6, 1'b1);
        checkOutput("n6_first_an", AN6, 6'h3F);
      end
      if (k == 96) checkOutput("n6_fs_low_end", frameStart6, 1'b0);
      if (k == 97) checkOutput("n6_fs_period96", frameStart6, 1'b1);
      if ((k % 16) == 6) begin
        s = ((k - 1) / 16) % 6;
        an6Exp    = 6'h3F;
        an6Exp[s] = 1'b0;
        checkOutput("n6_an", AN6, an6Exp);
        checkOutput("n6_hex", HEX6, hexLetters[s]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NDIGITS, default 8, is the number of multiplexed digits, legal range 1..16.
REQ-002 Parameter DWELL_MUL, default 1, is the clocks per PWM phase; a digit slot lasts DWELL = 16*DWELL_MUL clocks.
REQ-003 Parameter BLINK_FRAMES, default 64, is the full scan frames per blink half-period, legal range >= 1.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 digit_val  in  4*NDIGITS  hex nibble per digit; digit i occupies bits [4i+3:4i].
REQ-007 dot  in  NDIGITS  1 = decimal point of digit i lit.
REQ-008 en  in  NDIGITS  1 = digit i enabled.
REQ-009 blink  in  NDIGITS  1 = digit i blanked during the blink-off half-period.
REQ-010 brightness  in  4  PWM level: 0 = dimmest, 15 = brightest.
REQ-011 AN  out  NDIGITS  digit anodes, active-low, registered.
REQ-012 HEX  out  8  segments, active-low, registered; bits [6:0] = g..a, bit 7 = dp.
REQ-013 frame_start  out  1  one-clock pulse marking output of slot 0, clock 0.

Function
REQ-014 Internal state: sel (0..NDIGITS-1), cnt (0..DWELL-1), frame counter fcnt (0..BLINK_FRAMES-1), and blink_off (1 bit).
- cnt increments every clock.
- On cnt = DWELL-1: cnt -> 0 and sel -> sel+1, wrapping NDIGITS-1 -> 0 (non-power-of-2 NDIGITS included).
- NDIGITS = 1: sel stays 0.
REQ-015 On the wrap (sel = NDIGITS-1, cnt = DWELL-1):
- fcnt increments.
- When fcnt = BLINK_FRAMES-1, fcnt -> 0 and blink_off toggles.
REQ-016 AN and HEX are computed from the pre-edge state and the current inputs, then registered, so they show state with one clock of latency.
REQ-017 Let phase = cnt / DWELL_MUL (0..15). Digit sel is lit only when all of the following hold:
- cnt != 0 (anti-ghost blank on the first clock of every slot)
- phase <= brightness
- en[sel] = 1
- NOT (blink[sel] AND blink_off)
REQ-018 Lit: AN = all ones except bit sel = 0; HEX[6:0] = decode(digit_val[sel]); HEX[7] = ~dot[sel].
REQ-019 Not lit: AN = all ones and HEX = 8'hFF.
REQ-020 A disabled or blanked digit still occupies its full slot; slots are never skipped, so frame length is always NDIGITS*DWELL clocks.
REQ-021 decode (g..a), active-low:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-022 frame_start is registered and is 1 exactly for the clock whose outputs were computed from sel = 0, cnt = 0 with rst = 1; otherwise 0.
REQ-023 Input changes take effect on the next clock edge; inputs are not latched per frame.

Reset
REQ-024 A posedge with rst = 0 forces sel = 0, cnt = 0, fcnt = 0, blink_off = 0, AN = all ones, HEX = 8'hFF, frame_start = 0, regardless of current state (mid-slot included).
REQ-025 The first posedge with rst = 1 computes outputs from sel = 0, cnt = 0: AN all ones, frame_start = 1.

Verification (NDIGITS=8, DWELL_MUL=1, BLINK_FRAMES=2 unless stated)
REQ-026 rst held low 5 clocks with arbitrary inputs -> AN = 8'hFF, HEX = 8'hFF, frame_start = 0 throughout.
REQ-027 Release rst; en = 8'hFF, brightness = 15, dot = 0, digit_val = 32'h76543210 ->
- edge 1: AN = FF, frame_start = 1
- edges 2..16: AN = FE, HEX = C0
- edge 17: AN = FF
- edges 18..32: AN = FD, HEX = F9
REQ-028 brightness = 3, dot[0] = 1 -> digit 0 lit only on edges 2..4 of its slot (AN = FE, HEX = 40), blank on edges 5..16.
REQ-029 blink = 8'h04, en[5] = 0 ->
- digit 2 lit in frames 0-1, blank in frames 2-3, lit again in frame 4
- AN[5] never 0
- frame_start period = 128 clocks
REQ-030 NDIGITS = 6 instance -> sel sequence 0..5,0; frame_start period = 96 clocks; AN is 6 bits wide.
REQ-031 rst low for one edge mid-slot (sel = 3, cnt = 9) -> next output AN = all ones, HEX = FF; the following edge shows frame_start = 1, and scanning restarts at digit 0.
